// File: rtl/rdata_chan_mngr.sv
`default_nettype none
// ============================================================================
// Module   : rdata_chan_mngr
// Brief    : Manager-side AXI R channel; packs a 4-beat 32-bit read burst into
//            one 128-bit line held until acknowledged, flagging length errors.
//            Optional macro RDATA_M_IDCHK_EN adds a per-beat rid vs exp_id check.
// Revision : 1.0 - initial release
// ============================================================================
module rdata_chan_mngr #(
    parameter int BEATS = 4,
    parameter int IDW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rvalid,
    output logic             rready,
    input  logic [IDW-1:0]   rid,
    input  logic [31:0]      rdata,
    input  logic             rlast,
    output logic             rdata_m_valid,
    output logic [IDW-1:0]   rdata_m_id,
    output logic [127:0]     rdata_m_data,
    output logic             rdata_m_err,
    input  logic             rdata_m_ack,
    input  logic [IDW-1:0]   exp_id
);

    typedef enum logic [1:0] {
        RDAT_MRECV = 2'd0,
        RDAT_MHOLD = 2'd1,
        RDAT_MDEFO = 2'd2
    } state_t;

    localparam logic [1:0] c_LAST_BEAT = 2'(BEATS - 1);

    state_t         r_state;
    logic [1:0]     r_cntr;
    logic [127:0]   r_data;
    logic [IDW-1:0] r_id;
    logic           r_err;

    logic w_accept;
    logic w_last_lane;
    logic w_done;
    logic w_len_err;
    logic w_burst_id_err;

    assign rready        = (r_state != RDAT_MHOLD);
    assign rdata_m_valid = (r_state == RDAT_MHOLD);
    assign rdata_m_data  = r_data;
    assign rdata_m_id    = r_id;
    assign rdata_m_err   = r_err;

    assign w_accept    = rvalid & rready;
    assign w_last_lane = (r_cntr == c_LAST_BEAT);
    assign w_done      = rlast | w_last_lane;
    // rlast early (short) or missing on the last lane (long) are both errors
    assign w_len_err   = rlast ^ w_last_lane;

`ifdef RDATA_M_IDCHK_EN
    logic r_id_err;
    logic w_id_mis;

    assign w_id_mis       = (rid != exp_id);
    assign w_burst_id_err = (r_cntr == 2'd0) ? w_id_mis : (r_id_err | w_id_mis);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_err <= 1'b0;
        end else if ((r_state == RDAT_MRECV) && w_accept) begin
            r_id_err <= w_burst_id_err;
        end
    end
`else
    logic w_unused_exp_id;

    assign w_unused_exp_id = ^exp_id;
    assign w_burst_id_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RDAT_MRECV;
            r_cntr  <= 2'd0;
            r_data  <= 128'd0;
            r_id    <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                RDAT_MRECV: begin
                    if (w_accept) begin
                        // beat 0 wipes the stale upper lanes so short bursts read as zero
                        case (r_cntr)
                            2'd0: begin
                                r_data <= {96'd0, rdata};
                                r_id   <= rid;
                            end
                            2'd1:    r_data[63:32]  <= rdata;
                            2'd2:    r_data[95:64]  <= rdata;
                            default: r_data[127:96] <= rdata;
                        endcase
                        if (w_done) begin
                            r_state <= RDAT_MHOLD;
                            r_cntr  <= 2'd0;
                            r_err   <= w_len_err | w_burst_id_err;
                        end else begin
                            r_cntr  <= r_cntr + 2'd1;
                        end
                    end
                end
                RDAT_MHOLD: begin
                    if (rdata_m_ack) begin
                        r_state <= RDAT_MRECV;
                    end
                end
                default: begin
                    r_state <= RDAT_MRECV;
                    r_cntr  <= 2'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rdata_chan_mngr.sv
`default_nettype none
// ============================================================================
// Module   : tb_rdata_chan_mngr
// Brief    : Directed self-checking bench for rdata_chan_mngr with a line
//            scoreboard. Honours RDATA_M_IDCHK_EN for the rid-check step.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rdata_chan_mngr;

    localparam int c_IDW = 4;

    logic             clk;
    logic             rst;
    logic             rvalid;
    logic             rready;
    logic [c_IDW-1:0] rid;
    logic [31:0]      rdata;
    logic             rlast;
    logic             rdata_m_valid;
    logic [c_IDW-1:0] rdata_m_id;
    logic [127:0]     rdata_m_data;
    logic             rdata_m_err;
    logic             rdata_m_ack;
    logic [c_IDW-1:0] exp_id;

    typedef struct packed {
        logic [c_IDW-1:0] id;
        logic [127:0]     data;
        logic             err;
    } line_t;

    line_t sb_q[$];
    line_t r_cur;
    int    n_checks = 0;
    int    n_errs   = 0;

    rdata_chan_mngr #(.BEATS(4), .IDW(c_IDW)) dut (
        .clk           (clk),
        .rst           (rst),
        .rvalid        (rvalid),
        .rready        (rready),
        .rid           (rid),
        .rdata         (rdata),
        .rlast         (rlast),
        .rdata_m_valid (rdata_m_valid),
        .rdata_m_id    (rdata_m_id),
        .rdata_m_data  (rdata_m_data),
        .rdata_m_err   (rdata_m_err),
        .rdata_m_ack   (rdata_m_ack),
        .exp_id        (exp_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [c_IDW-1:0] id, input logic [31:0] d, input logic last);
        int g;
        rid    = id;
        rdata  = d;
        rlast  = last;
        rvalid = 1'b1;
        g = 0;
        while (rready !== 1'b1 && g < 20) begin
            step();
            g++;
        end
        if (g >= 20) chk("beat_timeout", 128'd0, 128'd1);
        step();
    endtask

    task automatic idle_bus();
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic check_line(input string tag, output line_t got);
        chk({tag, "_valid"}, 128'(rdata_m_valid), 128'd1);
        chk({tag, "_rready"}, 128'(rready), 128'd0);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 128'd0, 128'd1);
            got = '0;
        end else begin
            got = sb_q.pop_front();
            chk({tag, "_data"}, rdata_m_data, got.data);
            chk({tag, "_id"}, 128'(rdata_m_id), 128'(got.id));
            chk({tag, "_err"}, 128'(rdata_m_err), 128'(got.err));
        end
    endtask

    task automatic do_ack(input string tag);
        idle_bus();
        rdata_m_ack = 1'b1;
        step();
        rdata_m_ack = 1'b0;
        chk({tag, "_ack_valid"}, 128'(rdata_m_valid), 128'd0);
        chk({tag, "_ack_rready"}, 128'(rready), 128'd1);
    endtask

    initial begin
        rst         = 1'b1;
        rvalid      = 1'b0;
        rid         = '0;
        rdata       = '0;
        rlast       = 1'b0;
        rdata_m_ack = 1'b0;
        exp_id      = '0;
        step();
        step();
        rst = 1'b0;

        chk("rst_valid", 128'(rdata_m_valid), 128'd0);
        chk("rst_rready", 128'(rready), 128'd1);
        chk("rst_data", rdata_m_data, 128'd0);
        chk("rst_id", 128'(rdata_m_id), 128'd0);
        chk("rst_err", 128'(rdata_m_err), 128'd0);

        // Clean four-beat burst, back-to-back
        exp_id = 4'h5;
        sb_q.push_back('{id: 4'h5, data: 128'h44444444_33333333_22222222_11111111, err: 1'b0});
        send_beat(4'h5, 32'h11111111, 1'b0);
        send_beat(4'h5, 32'h22222222, 1'b0);
        send_beat(4'h5, 32'h33333333, 1'b0);
        send_beat(4'h5, 32'h44444444, 1'b1);
        idle_bus();
        check_line("burst4", r_cur);

        // Backpressure: beats offered while holding must not be consumed
        rvalid = 1'b1;
        rdata  = 32'hDEADBEEF;
        rlast  = 1'b1;
        rid    = 4'hF;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_rready", 128'(rready), 128'd0);
        end
        chk("hold_data", rdata_m_data, r_cur.data);
        chk("hold_id", 128'(rdata_m_id), 128'(r_cur.id));
        do_ack("hold");

        // Ack while not holding is ignored
        rdata_m_ack = 1'b1;
        step();
        rdata_m_ack = 1'b0;
        chk("stray_ack_valid", 128'(rdata_m_valid), 128'd0);
        chk("stray_ack_rready", 128'(rready), 128'd1);

        // Short burst: two beats then rlast
        exp_id = 4'h7;
        sb_q.push_back('{id: 4'h7, data: {64'd0, 32'hB1B1B1B1, 32'hA0A0A0A0}, err: 1'b1});
        send_beat(4'h7, 32'hA0A0A0A0, 1'b0);
        send_beat(4'h7, 32'hB1B1B1B1, 1'b1);
        idle_bus();
        check_line("short", r_cur);
        do_ack("short");

        // Long burst: no rlast on beat 4, then a 5th beat offered
        exp_id = 4'h2;
        sb_q.push_back('{id: 4'h2, data: 128'h0000000D_0000000C_0000000B_0000000A, err: 1'b1});
        send_beat(4'h2, 32'h0000000A, 1'b0);
        send_beat(4'h2, 32'h0000000B, 1'b0);
        send_beat(4'h2, 32'h0000000C, 1'b0);
        send_beat(4'h2, 32'h0000000D, 1'b0);
        rdata = 32'h0000000E;
        check_line("long", r_cur);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("long_5th_rready", 128'(rready), 128'd0);
        end
        chk("long_5th_data", rdata_m_data, r_cur.data);
        do_ack("long");

        // Reset mid-burst discards partial data
        exp_id = 4'h9;
        send_beat(4'h9, 32'hCAFE0000, 1'b0);
        send_beat(4'h9, 32'hCAFE0001, 1'b0);
        idle_bus();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("midrst_valid", 128'(rdata_m_valid), 128'd0);
            step();
        end
        chk("midrst_data", rdata_m_data, 128'd0);
        exp_id = 4'hA;
        sb_q.push_back('{id: 4'hA, data: 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, err: 1'b0});
        send_beat(4'hA, 32'h0A0A0A0A, 1'b0);
        send_beat(4'hA, 32'h0B0B0B0B, 1'b0);
        send_beat(4'hA, 32'h0C0C0C0C, 1'b0);
        send_beat(4'hA, 32'h0D0D0D0D, 1'b1);
        idle_bus();
        check_line("after_rst", r_cur);
        do_ack("after_rst");

        // rid mismatch on beat 2: flagged only when the id check is built in
        exp_id = 4'h3;
`ifdef RDATA_M_IDCHK_EN
        sb_q.push_back('{id: 4'h3, data: 128'h00000004_00000003_00000002_00000001, err: 1'b1});
`else
        sb_q.push_back('{id: 4'h3, data: 128'h00000004_00000003_00000002_00000001, err: 1'b0});
`endif
        send_beat(4'h3, 32'h00000001, 1'b0);
        send_beat(4'h3, 32'h00000002, 1'b0);
        send_beat(4'h4, 32'h00000003, 1'b0);
        send_beat(4'h3, 32'h00000004, 1'b1);
        idle_bus();
        check_line("idchk", r_cur);
        do_ack("idchk");

        chk("sb_drained", 128'(sb_q.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
`default_nettype wire
